// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path: opcodes, funct3, FSM states,
// datapath select values and the instruction-class decoder.
package riscv_ctrl_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [2:0] F3_LB   = 3'b000;
   localparam logic [2:0] F3_SB   = 3'b000;
   localparam logic [2:0] F3_ADDI = 3'b000;
   localparam logic [2:0] F3_ORI  = 3'b110;
   localparam logic [2:0] F3_BEQ  = 3'b000;

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP
   } state_e;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_OR  = 2'b10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MDR = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   localparam logic PC_PLUS4 = 1'b0;
   localparam logic PC_IMM   = 1'b1;

   typedef enum logic [2:0] {
      INS_ILLEGAL, INS_LB, INS_SB, INS_ADDI, INS_ORI, INS_BEQ, INS_J
   } instr_e;

   // Map IR opcode/funct3 to one of the supported instruction classes.
   function automatic instr_e decode_instr(input logic [6:0] opc, input logic [2:0] f3);
      instr_e cls;
      cls = INS_ILLEGAL;
      case (opc)
         OPC_LOAD:   if (f3 == F3_LB) cls = INS_LB;
         OPC_STORE:  if (f3 == F3_SB) cls = INS_SB;
         OPC_OPIMM: begin
            if (f3 == F3_ADDI)     cls = INS_ADDI;
            else if (f3 == F3_ORI) cls = INS_ORI;
         end
         OPC_BRANCH: if (f3 == F3_BEQ) cls = INS_BEQ;
         OPC_JAL:    cls = INS_J;
         default:    cls = INS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Bounded-wait counter for the memory handshake; expires after MEM_TIMEOUT-1 counted cycles.
module ctrl_wait_timer
#(
   parameter int unsigned MEM_TIMEOUT = 16
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired_c
);

   localparam int unsigned CW = $clog2(MEM_TIMEOUT);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_count <= '0;
      else if (i_clear)  r_count <= '0;
      else if (i_enable) r_count <= r_count + CW'(1);
   end

   assign o_expired_c = (r_count == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback, owns the memory
// handshake timeout, the illegal-instruction trap and the retired-instruction counter.
module multicycle_control
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             alu_zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             ir_write,
   output logic             mdr_write,
   output logic             alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_write,
   output logic [1:0]       wb_sel,
   output logic             pc_write,
   output logic             pc_src,
   output logic             retire,
   output logic             trap,
   output logic [CNT_W-1:0] instret
);

   state_e           r_state;
   state_e           w_state_next;
   instr_e           w_instr;
   logic             w_wait_state;
   logic             w_tmr_clear;
   logic             w_tmr_en;
   logic             w_tmr_expired;
   logic [CNT_W-1:0] r_instret;

   assign w_instr      = decode_instr(opcode, funct3);
   assign w_wait_state = (r_state == FETCH) || (r_state == MEM);
   // Timer restarts on every state change and on every accepted request.
   assign w_tmr_clear  = !w_wait_state || mem_ready || (w_state_next != r_state);
   assign w_tmr_en     = w_wait_state && !mem_ready;

   ctrl_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clear     (w_tmr_clear),
      .i_enable    (w_tmr_en),
      .o_expired_c (w_tmr_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state and output decode.
   always_comb begin
      w_state_next = r_state;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_write     = 1'b0;
      mdr_write    = 1'b0;
      alu_src_b    = 1'b0;
      alu_op       = ALU_ADD;
      reg_write    = 1'b0;
      wb_sel       = WB_ALU;
      pc_write     = 1'b0;
      pc_src       = PC_PLUS4;
      trap         = 1'b0;

      case (r_state)
         IDLE: w_state_next = FETCH;

         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write     = 1'b1;
               w_state_next = DECODE;
            end else if (w_tmr_expired) begin
               w_state_next = TRAP;
            end
         end

         DECODE: w_state_next = (w_instr == INS_ILLEGAL) ? TRAP : EXEC;

         EXEC: begin
            case (w_instr)
               INS_ADDI, INS_ORI: begin
                  alu_src_b    = 1'b1;
                  alu_op       = (w_instr == INS_ORI) ? ALU_OR : ALU_ADD;
                  w_state_next = WB;
               end
               INS_LB, INS_SB: begin
                  alu_src_b    = 1'b1;
                  w_state_next = MEM;
               end
               INS_BEQ: begin
                  alu_op       = ALU_SUB;
                  pc_write     = 1'b1;
                  pc_src       = alu_zero;
                  w_state_next = FETCH;
               end
               INS_J: begin
                  pc_write     = 1'b1;
                  pc_src       = PC_IMM;
                  reg_write    = 1'b1;
                  wb_sel       = WB_PC4;
                  w_state_next = FETCH;
               end
               default: w_state_next = TRAP;
            endcase
         end

         MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            alu_src_b    = 1'b1;
            mem_we       = (w_instr == INS_SB);
            if (mem_ready) begin
               if (w_instr == INS_SB) begin
                  pc_write     = 1'b1;
                  w_state_next = FETCH;
               end else begin
                  mdr_write    = 1'b1;
                  w_state_next = WB;
               end
            end else if (w_tmr_expired) begin
               w_state_next = TRAP;
            end
         end

         WB: begin
            reg_write    = 1'b1;
            pc_write     = 1'b1;
            pc_src       = PC_PLUS4;
            w_state_next = FETCH;
            if (w_instr == INS_LB) begin
               wb_sel = WB_MDR;
            end else begin
               alu_src_b = 1'b1;
               alu_op    = (w_instr == INS_ORI) ? ALU_OR : ALU_ADD;
               wb_sel    = WB_ALU;
            end
         end

         TRAP: trap = 1'b1;

         default: w_state_next = IDLE;
      endcase
   end

   assign retire = pc_write;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_instret <= '0;
      else if (pc_write) r_instret <= r_instret + CNT_W'(1);
   end

   assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table of per-instruction expectations, hand-timed reset and
// trap sequences, and randomized instructions/wait states against an instruction-level model.
module tb_multicycle_control;

   localparam int unsigned TO = 16;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [6:0]    opcode;
   logic [2:0]    funct3;
   logic          alu_zero;
   logic          mem_ready;
   logic          mem_req, mem_we, mem_addr_sel, ir_write, mdr_write, alu_src_b;
   logic [1:0]    alu_op, wb_sel;
   logic          reg_write, pc_write, pc_src, retire, trap;
   logic [CW-1:0] instret;
   logic [14:0]   all_outs;

   multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .alu_zero(alu_zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
      .ir_write(ir_write), .mdr_write(mdr_write), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .reg_write(reg_write), .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src),
      .retire(retire), .trap(trap), .instret(instret)
   );

   always #5 clk = ~clk;

   assign all_outs = {mem_req, mem_we, mem_addr_sel, ir_write, mdr_write, alu_src_b, alu_op,
                      reg_write, wb_sel, pc_write, pc_src, retire, trap};

   typedef struct {
      logic       trap;
      int         cycles;
      int         regw;
      int         mdrw;
      logic [1:0] wb_sel;
      logic       pc_src;
      logic [1:0] alu_op;
      logic       chk_alu;
      logic       is_mem;
      logic       we;
   } exp_t;

   typedef struct {
      logic [6:0] opc;
      logic [2:0] f3;
      logic       zero;
      int         fw;
      int         mw;
      exp_t       e;
   } vec_t;

   typedef struct {
      int         cycles;
      int         pcw;
      int         irw;
      int         regw;
      int         mdrw;
      logic [1:0] wb_sel;
      logic       pc_src;
      logic       src_b;
      logic [1:0] alu_op;
      logic       we_data;
      logic       we_fetch;
      logic       sel_err;
      logic       unstable;
      logic       ret_err;
      logic       trapped;
      logic       done;
   } obs_t;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [CW-1:0] exp_instret;
   vec_t          vecs[14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Instruction-level expectations straight from the ISA subset and latency rules.
   function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic zero,
                                  input int fw, input int mw);
      exp_t e;
      logic is_lb, is_sb, is_addi, is_ori, is_beq, is_j;
      int   base;
      is_lb   = (opc == 7'h03) && (f3 == 3'd0);
      is_sb   = (opc == 7'h23) && (f3 == 3'd0);
      is_addi = (opc == 7'h13) && (f3 == 3'd0);
      is_ori  = (opc == 7'h13) && (f3 == 3'd6);
      is_beq  = (opc == 7'h63) && (f3 == 3'd0);
      is_j    = (opc == 7'h6f);
      e.is_mem  = is_lb | is_sb;
      e.we      = is_sb;
      e.regw    = (is_lb | is_addi | is_ori | is_j) ? 1 : 0;
      e.mdrw    = is_lb ? 1 : 0;
      e.wb_sel  = is_lb ? 2'b01 : (is_j ? 2'b10 : 2'b00);
      e.pc_src  = is_j | (is_beq & zero);
      e.chk_alu = is_addi | is_ori;
      e.alu_op  = is_ori ? 2'b10 : 2'b00;
      base      = is_lb ? 5 : ((is_beq | is_j) ? 3 : 4);
      e.cycles  = base + fw + (e.is_mem ? mw : 0);
      e.trap    = !(is_lb | is_sb | is_addi | is_ori | is_beq | is_j) ||
                  (fw >= int'(TO)) || (e.is_mem && (mw >= int'(TO)));
      return e;
   endfunction

   function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic zero,
                               input int fw, input int mw, input logic tr, input int cyc,
                               input int regw, input int mdrw, input logic [1:0] wbs,
                               input logic pcs, input logic [1:0] aop, input logic chk,
                               input logic is_mem, input logic we);
      vec_t v;
      v.opc = opc; v.f3 = f3; v.zero = zero; v.fw = fw; v.mw = mw;
      v.e.trap = tr; v.e.cycles = cyc; v.e.regw = regw; v.e.mdrw = mdrw; v.e.wb_sel = wbs;
      v.e.pc_src = pcs; v.e.alu_op = aop; v.e.chk_alu = chk; v.e.is_mem = is_mem; v.e.we = we;
      return v;
   endfunction

   // Asynchronous reset from any point, then release and step into FETCH.
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      mem_ready = 1'b0;
      #1;
      check($sformatf("%s.rst_outs", tag), all_outs, 0);
      check($sformatf("%s.rst_instret", tag), instret, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_instret = '0;
      check($sformatf("%s.idle_req", tag), mem_req, 0);
      @(posedge clk); #1;
      check($sformatf("%s.fetch_req", tag), mem_req, 1);
   endtask

   // Drive one instruction from the start of FETCH until retirement or trap.
   task automatic run_instr(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                            input logic zero, input int fw, input int mw, input logic noise,
                            output obs_t o);
      int   waited, phase;
      logic first, we0, sel0;
      o.cycles = 0; o.pcw = 0; o.irw = 0; o.regw = 0; o.mdrw = 0; o.wb_sel = 2'b00;
      o.pc_src = 1'b0; o.src_b = 1'b0; o.alu_op = 2'b00; o.we_data = 1'b0; o.we_fetch = 1'b0;
      o.sel_err = 1'b0; o.unstable = 1'b0; o.ret_err = 1'b0; o.trapped = 1'b0; o.done = 1'b0;
      opcode = opc; funct3 = f3; alu_zero = zero;
      waited = 0; phase = 0; first = 1'b1; we0 = 1'b0; sel0 = 1'b0;
      for (int cyc = 0; cyc < 200 && !o.done && !o.trapped; cyc++) begin
         if (mem_req) mem_ready = (waited >= ((phase == 0) ? fw : mw));
         else         mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         o.cycles++;
         if (trap) begin
            o.trapped = 1'b1;
         end else begin
            if (mem_req) begin
               if (first) begin
                  we0 = mem_we; sel0 = mem_addr_sel; first = 1'b0;
               end else if (mem_we != we0 || mem_addr_sel != sel0) begin
                  o.unstable = 1'b1;
               end
               if (mem_addr_sel != (phase == 1)) o.sel_err = 1'b1;
               if (phase == 0) o.we_fetch |= mem_we;
               else            o.we_data  |= mem_we;
               if (mem_ready) begin
                  waited = 0; phase = 1; first = 1'b1;
               end else begin
                  waited++;
               end
            end
            if (ir_write)  o.irw++;
            if (mdr_write) o.mdrw++;
            if (reg_write) begin
               o.regw++; o.wb_sel = wb_sel; o.src_b = alu_src_b; o.alu_op = alu_op;
            end
            if (retire != pc_write) o.ret_err = 1'b1;
            if (pc_write) begin
               o.pcw++; o.pc_src = pc_src; o.done = 1'b1;
            end
         end
         @(posedge clk); #1;
      end
      check($sformatf("%s.ended", tag), o.done | o.trapped, 1);
   endtask

   task automatic check_obs(input string tag, input exp_t e, input obs_t o);
      check($sformatf("%s.trap", tag), o.trapped, e.trap);
      if (!e.trap) begin
         exp_instret = exp_instret + 1'b1;
         check($sformatf("%s.cycles", tag), o.cycles, e.cycles);
         check($sformatf("%s.pc_writes", tag), o.pcw, 1);
         check($sformatf("%s.ir_writes", tag), o.irw, 1);
         check($sformatf("%s.reg_writes", tag), o.regw, e.regw);
         check($sformatf("%s.mdr_writes", tag), o.mdrw, e.mdrw);
         check($sformatf("%s.pc_src", tag), o.pc_src, e.pc_src);
         check($sformatf("%s.retire_eq", tag), o.ret_err, 0);
         check($sformatf("%s.fetch_we", tag), o.we_fetch, 0);
         check($sformatf("%s.addr_sel", tag), o.sel_err, 0);
         check($sformatf("%s.req_stable", tag), o.unstable, 0);
         check($sformatf("%s.instret", tag), instret, exp_instret);
         if (e.regw != 0) check($sformatf("%s.wb_sel", tag), o.wb_sel, e.wb_sel);
         if (e.chk_alu) begin
            check($sformatf("%s.wb_src_b", tag), o.src_b, 1);
            check($sformatf("%s.wb_alu_op", tag), o.alu_op, e.alu_op);
         end
         if (e.is_mem) check($sformatf("%s.mem_we", tag), o.we_data, e.we);
      end
   endtask

   task automatic trap_sticky(input string tag);
      for (int i = 0; i < 4; i++) begin
         mem_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         check($sformatf("%s.sticky%0d", tag, i), trap, 1);
         check($sformatf("%s.quiet%0d", tag, i), all_outs[14:1], 0);
         @(posedge clk); #1;
      end
      check($sformatf("%s.instret_hold", tag), instret, exp_instret);
   endtask

   initial begin
      obs_t       o;
      exp_t       e;
      logic [6:0] opc, legal_opc[6];
      logic [2:0] f3;
      logic       zero;
      int         fw, mw, k;

      legal_opc[0] = 7'h03; legal_opc[1] = 7'h23; legal_opc[2] = 7'h13;
      legal_opc[3] = 7'h13; legal_opc[4] = 7'h63; legal_opc[5] = 7'h6f;

      //           opc    f3    z    fw  mw  trap cyc rw md wb     pcs   aop    chk  mem  we
      vecs[0]  = mk(7'h13, 3'd0, 0,  0,  0, 0,  4, 1, 0, 2'b00, 1'b0, 2'b00, 1, 0, 0);
      vecs[1]  = mk(7'h03, 3'd0, 0,  0,  3, 0,  8, 1, 1, 2'b01, 1'b0, 2'b00, 0, 1, 0);
      vecs[2]  = mk(7'h63, 3'd0, 1,  0,  0, 0,  3, 0, 0, 2'b00, 1'b1, 2'b00, 0, 0, 0);
      vecs[3]  = mk(7'h63, 3'd0, 0,  0,  0, 0,  3, 0, 0, 2'b00, 1'b0, 2'b00, 0, 0, 0);
      vecs[4]  = mk(7'h6f, 3'd5, 0,  0,  0, 0,  3, 1, 0, 2'b10, 1'b1, 2'b00, 0, 0, 0);
      vecs[5]  = mk(7'h23, 3'd0, 0,  2,  1, 0,  7, 0, 0, 2'b00, 1'b0, 2'b00, 0, 1, 1);
      vecs[6]  = mk(7'h13, 3'd6, 0,  1,  0, 0,  5, 1, 0, 2'b00, 1'b0, 2'b10, 1, 0, 0);
      vecs[7]  = mk(7'h03, 3'd0, 0, 15, 15, 0, 35, 1, 1, 2'b01, 1'b0, 2'b00, 0, 1, 0);
      vecs[8]  = mk(7'h23, 3'd0, 0,  0, 15, 0, 19, 0, 0, 2'b00, 1'b0, 2'b00, 0, 1, 1);
      vecs[9]  = mk(7'h13, 3'd0, 1,  3,  0, 0,  7, 1, 0, 2'b00, 1'b0, 2'b00, 1, 0, 0);
      vecs[10] = mk(7'h33, 3'd0, 0,  0,  0, 1,  0, 0, 0, 2'b00, 1'b0, 2'b00, 0, 0, 0);
      vecs[11] = mk(7'h13, 3'd7, 0,  0,  0, 1,  0, 0, 0, 2'b00, 1'b0, 2'b00, 0, 0, 0);
      vecs[12] = mk(7'h13, 3'd0, 0, 16,  0, 1,  0, 0, 0, 2'b00, 1'b0, 2'b00, 0, 0, 0);
      vecs[13] = mk(7'h03, 3'd0, 0,  0, 16, 1,  0, 0, 0, 2'b00, 1'b0, 2'b00, 0, 1, 0);

      rst_n = 1'b1; opcode = 7'h0; funct3 = 3'h0; alu_zero = 1'b0; mem_ready = 1'b0;
      exp_instret = '0;
      #1;
      do_reset("init");

      for (int i = 0; i < 14; i++) begin
         run_instr($sformatf("vec%0d", i), vecs[i].opc, vecs[i].f3, vecs[i].zero,
                   vecs[i].fw, vecs[i].mw, 1'b0, o);
         check_obs($sformatf("vec%0d", i), vecs[i].e, o);
         if (o.trapped) trap_sticky($sformatf("vec%0d", i));
         if (o.trapped || vecs[i].e.trap) do_reset($sformatf("vec%0d", i));
      end

      // Retire one ADDI, then pull reset asynchronously while an LB waits in MEM.
      run_instr("addi_pre", 7'h13, 3'd0, 1'b0, 0, 0, 1'b0, o);
      check_obs("addi_pre", model(7'h13, 3'd0, 1'b0, 0, 0), o);
      opcode = 7'h03; funct3 = 3'd0; mem_ready = 1'b1;
      @(negedge clk);
      check("mm.ir_write", ir_write, 1);
      @(posedge clk); #1; mem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("mm.mem_hs", {mem_req, mem_we, mem_addr_sel, trap}, 4'b1010);
      #2;
      do_reset("mm");

      for (int n = 0; n < 120; n++) begin
         k = int'($urandom_range(0, 7));
         if (k < 6) begin
            opc = legal_opc[k];
            f3  = (k == 3) ? 3'd6 : ((k == 5) ? 3'($urandom) : 3'd0);
         end else if (k == 6) begin
            opc = legal_opc[$urandom_range(0, 5)];
            f3  = 3'($urandom);
         end else begin
            opc = 7'($urandom);
            f3  = 3'($urandom);
         end
         zero = 1'($urandom_range(0, 1));
         k  = int'($urandom_range(0, 19));
         fw = (k < 14) ? int'($urandom_range(0, 3)) : ((k < 19) ? int'($urandom_range(12, 15)) : 16);
         k  = int'($urandom_range(0, 19));
         mw = (k < 14) ? int'($urandom_range(0, 3)) : ((k < 19) ? int'($urandom_range(12, 15)) : 17);
         e = model(opc, f3, zero, fw, mw);
         run_instr($sformatf("rnd%0d", n), opc, f3, zero, fw, mw, 1'b1, o);
         check_obs($sformatf("rnd%0d", n), e, o);
         if (o.trapped) trap_sticky($sformatf("rnd%0d", n));
         if (o.trapped || e.trap) do_reset($sformatf("rnd%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
